// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I width codes and the
// byte-enable generator.
package lsu_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Loads always fetch the whole word; only stores narrow the enables.
  function automatic logic [3:0] be_gen(input logic we, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (we) begin
      case (f3)
        F3_B:    be = 4'b0001 << off;
        F3_H:    be = 4'b0011 << {off[1], 1'b0};
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load-data formatter: selects the addressed byte/half of a bus word and
// sign- or zero-extends it to 32 bits.
module load_formatter
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] word_i,
  output logic [31:0] result_o
);

  logic [31:0] lane;

  always_comb begin
    lane = word_i >> {off_i, 3'b000};
    case (funct3_i)
      F3_B:    result_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    result_o = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   result_o = {24'h0, lane[7:0]};
      F3_HU:   result_o = {16'h0, lane[15:0]};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store unit: issues word-aligned bus requests over a req/gnt/rvalid handshake,
// formats load data into a registered result, stalls the pipeline and flags errors.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        legal_f3, aligned, access_ok, idle, start, last;
  logic [31:0] wdata_fmt, fmt_rdata;

  always_comb begin
    if (mem_we) legal_f3 = funct3 inside {F3_B, F3_H, F3_W};
    else        legal_f3 = funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};

    case (funct3)
      F3_H, F3_HU: aligned = ~addr[0];
      F3_W:        aligned = (addr[1:0] == 2'b00);
      default:     aligned = 1'b1;
    endcase

    case (funct3)
      F3_B:    wdata_fmt = {4{store_data[7:0]}};
      F3_H:    wdata_fmt = {2{store_data[15:0]}};
      default: wdata_fmt = store_data;
    endcase
  end

  assign access_ok    = legal_f3 & aligned;
  assign idle         = (state_q == StIdle);
  assign start        = idle & mem_req & access_ok;
  assign misalign_err = idle & mem_req & ~access_ok;
  assign last         = (cnt_q == CntLast);

  load_formatter u_load_formatter (
    .funct3_i (f3_q),
    .off_i    (addr_q[1:0]),
    .word_i   (dmem_rdata),
    .result_o (fmt_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    bus_err = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReq;
          cnt_d   = '0;
          addr_d  = addr;
          f3_d    = funct3;
          we_d    = mem_we;
          be_d    = be_gen(mem_we, funct3, addr[1:0]);
          wdata_d = wdata_fmt;
        end
      end
      StReq: begin
        // A load granted on the final budget cycle still cannot complete, so it times out.
        if (dmem_gnt && we_q) begin
          state_d = StDone;
        end else if (last) begin
          bus_err = 1'b1;
          state_d = StDone;
          if (!we_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (dmem_gnt) state_d = StWait;
        end
      end
      StWait: begin
        if (dmem_rvalid) begin
          rdata_d = fmt_rdata;
          state_d = StDone;
        end else if (last) begin
          bus_err = 1'b1;
          rdata_d = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign rdata      = rdata_q;
  assign stall      = start | (state_q == StReq) | (state_q == StWait);
  assign dmem_req   = (state_q == StReq);
  assign dmem_we    = we_q;
  assign dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a reactive bus responder drives gnt/rvalid with chosen delays
// and each access is checked against hand-computed results.
module tb_lsu_ctrl;

  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int unsigned ADDR_W         = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mem_req, mem_we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       store_data;
  logic [31:0]       rdata;
  logic              stall, misalign_err, bus_err;
  logic              dmem_req, dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_gnt, dmem_rvalid;
  logic [31:0]       dmem_rdata;

  int checks = 0;
  int errors = 0;

  int          n_stall, n_req, n_err;
  logic        finished;
  logic [31:0] seen_addr, seen_wdata, done_rdata;
  logic [3:0]  seen_be;

  always #5 clk = ~clk;

  lsu_ctrl #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .ADDR_W         (ADDR_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .rdata        (rdata),
    .stall        (stall),
    .misalign_err (misalign_err),
    .bus_err      (bus_err),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one access from IDLE; gnt after gnt_dly request cycles, rvalid rv_dly cycles after gnt.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] word,
                        input int gnt_dly, input int rv_dly);
    int   req_cnt, gnt_cyc;
    logic granted;
    n_stall = 0; n_req = 0; n_err = 0; req_cnt = 0; gnt_cyc = 0;
    granted = 1'b0; finished = 1'b0;
    seen_addr = '0; seen_wdata = '0; seen_be = '0; done_rdata = '0;
    mem_req = 1'b1; mem_we = we; funct3 = f3; addr = a; store_data = sd;
    for (int c = 0; c < 60 && !finished; c++) begin
      dmem_gnt    = dmem_req && !granted && (req_cnt == gnt_dly);
      dmem_rvalid = granted && !we && ((c - gnt_cyc) == rv_dly);
      dmem_rdata  = word;
      #1;
      if (stall) n_stall++;
      if (bus_err) n_err++;
      if (dmem_req) begin
        req_cnt++;
        n_req++;
        seen_addr  = dmem_addr;
        seen_be    = dmem_be;
        seen_wdata = dmem_wdata;
      end
      if (dmem_gnt) begin
        granted = 1'b1;
        gnt_cyc = c;
      end
      if (c > 0 && !stall) begin
        finished   = 1'b1;
        done_rdata = rdata;
      end
      tick();
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; mem_req = 1'b0;
    check_eq("access_completes", 32'(finished), 32'd1);
    #1;
    check_eq("idle_after_done_req", 32'(dmem_req), 32'd0);
    check_eq("idle_after_done_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; funct3 = '0; addr = '0; store_data = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    #12;
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_dmem_req", 32'(dmem_req), 32'd0);
    check_eq("rst_dmem_be", 32'(dmem_be), 32'd0);
    check_eq("rst_bus_err", 32'(bus_err), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    access(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1);
    check_eq("lw_stall_cycles", n_stall, 3);
    check_eq("lw_addr", seen_addr, 32'h100);
    check_eq("lw_be", 32'(seen_be), 32'hF);
    check_eq("lw_rdata_done", done_rdata, 32'hDEADBEEF);

    access(1'b0, 3'b000, 32'h203, 32'h0, 32'h80FF_0000, 0, 1);
    check_eq("lb_rdata", done_rdata, 32'hFFFF_FF80);
    check_eq("lb_addr", seen_addr, 32'h200);
    access(1'b0, 3'b100, 32'h203, 32'h0, 32'h80FF_0000, 0, 1);
    check_eq("lbu_rdata", done_rdata, 32'h0000_0080);
    access(1'b0, 3'b001, 32'h202, 32'h0, 32'h80FF_0000, 0, 1);
    check_eq("lh_rdata", done_rdata, 32'hFFFF_80FF);
    access(1'b0, 3'b101, 32'h202, 32'h0, 32'h80FF_0000, 0, 1);
    check_eq("lhu_rdata", done_rdata, 32'h0000_80FF);

    access(1'b1, 3'b000, 32'h301, 32'h12345678, 32'hFFFF_FFFF, 0, 1);
    check_eq("sb_stall_cycles", n_stall, 2);
    check_eq("sb_be", 32'(seen_be), 32'h2);
    check_eq("sb_wdata", seen_wdata, 32'h78787878);
    check_eq("sb_rdata_kept", rdata, 32'h0000_80FF);
    access(1'b1, 3'b001, 32'h302, 32'h12345678, 32'h0, 0, 1);
    check_eq("sh_be", 32'(seen_be), 32'hC);
    check_eq("sh_wdata", seen_wdata, 32'h56785678);
    access(1'b1, 3'b010, 32'h304, 32'hA5A5_0F0F, 32'h0, 0, 1);
    check_eq("sw_be", 32'(seen_be), 32'hF);
    check_eq("sw_wdata", seen_wdata, 32'hA5A5_0F0F);

    // Misaligned and illegal requests must never reach the bus.
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b001; addr = 32'h101;
    #1;
    check_eq("lh_mis_err", 32'(misalign_err), 32'd1);
    check_eq("lh_mis_stall", 32'(stall), 32'd0);
    tick();
    check_eq("lh_mis_no_req", 32'(dmem_req), 32'd0);
    funct3 = 3'b011; addr = 32'h100;
    #1;
    check_eq("f3_011_err", 32'(misalign_err), 32'd1);
    tick();
    check_eq("f3_011_no_req", 32'(dmem_req), 32'd0);
    mem_we = 1'b1; funct3 = 3'b100;
    #1;
    check_eq("sbu_illegal_err", 32'(misalign_err), 32'd1);
    check_eq("mis_rdata_kept", rdata, 32'h0000_80FF);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();

    access(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFE_F00D, 3, 2);
    check_eq("slow_stall_cycles", n_stall, 7);
    check_eq("slow_req_cycles", n_req, 4);
    check_eq("slow_rdata", done_rdata, 32'hCAFE_F00D);
    check_eq("slow_no_bus_err", n_err, 0);

    access(1'b0, 3'b010, 32'h108, 32'h0, 32'h1111_2222, 99, 1);
    check_eq("to_stall_cycles", n_stall, TIMEOUT_CYCLES + 1);
    check_eq("to_bus_err_pulses", n_err, 1);
    check_eq("to_rdata", done_rdata, 32'h0);

    // Reset while waiting for read data.
    mem_req = 1'b1; mem_we = 1'b0; funct3 = 3'b010; addr = 32'h10C;
    tick();
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    #1;
    check_eq("pre_rst_in_wait", 32'(stall), 32'd1);
    mem_req = 1'b0; rst_n = 1'b0;
    #1;
    check_eq("rst_wait_req", 32'(dmem_req), 32'd0);
    check_eq("rst_wait_stall", 32'(stall), 32'd0);
    check_eq("rst_wait_addr", dmem_addr, 32'h0);
    check_eq("rst_wait_wdata", dmem_wdata, 32'h0);
    check_eq("rst_wait_rdata", rdata, 32'h0);
    #3 rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit sitting in the MEM stage between the pipeline and the data-memory bus. It is the producing end of the writeback load path: it issues word-aligned memory requests with byte enables and waits on a request/grant/rvalid handshake. It extracts and sign- or zero-extends load data into the registered rdata word that writeback selects with wb_sel=2'b10. It stalls the pipeline while a transaction is outstanding and flags misaligned or illegal accesses and bus timeouts.

Parameters:
TIMEOUT_CYCLES, 16, cycles spent in REQ+WAIT before a bus error is declared (min 2).
ADDR_W, 32, byte-address width.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
mem_req  input  1  MEM-stage instruction is a load/store; held stable while stall=1.
mem_we  input  1  1=store, 0=load.
funct3  input  3  RV32I width/sign code.
addr  input  ADDR_W  byte address from ALU.
store_data  input  32  rs2 value.
rdata  output  32  formatted load result to writeback (registered).
stall  output  1  freeze IF..MEM.
misalign_err  output  1  single-cycle flag; access not performed.
bus_err  output  1  single-cycle flag on timeout.
dmem_req  output  1  bus request.
dmem_we  output  1  bus write.
dmem_addr  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
dmem_be  output  4  byte enables.
dmem_wdata  output  32  lane-replicated store data.
dmem_gnt  input  1  request accepted this cycle.
dmem_rvalid  input  1  read data valid this cycle.
dmem_rdata  input  32  read word.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; rdata, dmem_*, flags, timeout counter and latched fields = 0. Reset mid-transaction drops dmem_req immediately and abandons the access.
- Legal funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads). Stores accept only 000/001/010.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0. Illegal funct3 is treated as misaligned.
- Misaligned or illegal in IDLE: misalign_err=1 (combinational, same cycle), stall=0, no bus activity, rdata unchanged.
- FSM IDLE->REQ->(WAIT)->DONE->IDLE:
  - IDLE: legal mem_req latches addr, funct3, we and data; go to REQ.
  - REQ: dmem_req=1 with latched fields. On dmem_gnt, a store goes to DONE and a load goes to WAIT.
  - WAIT: on dmem_rvalid, rdata <= formatted dmem_rdata; go to DONE. An rvalid arriving in the same cycle as gnt is not accepted; rvalid is sampled only in WAIT.
  - DONE: one cycle; stall=0, so the pipeline advances. Return to IDLE; the next mem_req is evaluated in IDLE.
- stall = mem_req legal in IDLE, or state in {REQ, WAIT}. It is 0 in DONE and 0 when no request is present.
- Minimum latency, gnt in first REQ cycle and rvalid the next cycle: load stalls 3 cycles, rdata valid in the DONE cycle. Store stalls 2 cycles.
- rdata holds its value until the next load completes; stores never modify it.
- Byte enables:
  - B: dmem_be = 4'b0001<<addr[1:0], wdata = {4{sd[7:0]}}.
  - H: dmem_be = 4'b0011<<{addr[1],1'b0}, wdata = {2{sd[15:0]}}.
  - W: dmem_be = 4'b1111, wdata = sd.
  - Loads drive dmem_be=4'b1111.
- Load extract: lane = dmem_rdata >> (8*addr[1:0]). B/H sign-extend from bit 7/15; BU/HU zero-extend.
- Timeout:
  - The counter clears on entering REQ and increments each REQ/WAIT cycle.
  - On reaching TIMEOUT_CYCLES-1 without completion: bus_err=1 for that cycle, rdata <= 0 for loads, go to DONE.
  - Late gnt/rvalid arriving after that point are ignored.

Decomposition:
- lsu_pkg:
  - state enum {IDLE, REQ, WAIT, DONE};
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU;
  - function for byte-enable generation.
- Sub-module load_formatter (combinational): funct3, addr[1:0], word in -> extended 32-bit result. Shared with a future cache path.

Test Plan:
- LW addr=0x100, gnt in first REQ cycle, rvalid next with rdata=0xDEADBEEF -> stall high 3 cycles, rdata=0xDEADBEEF in DONE, dmem_addr=0x100, be=1111.
- LB addr=0x203, rdata=0x80FF_0000 -> rdata=0xFFFF_FF80. LBU at the same address -> 0x0000_0080. LHU addr=0x202 -> 0x0000_80FF.
- SB addr=0x301, sd=0x12345678 -> dmem_be=0010, dmem_wdata=0x78787878, stall 2 cycles, rdata unchanged.
- LH addr=0x101, and funct3=3'b011 -> misalign_err=1 same cycle, stall=0, dmem_req never asserted.
- Load with gnt withheld for 3 cycles, then rvalid 2 cycles after gnt -> stall held throughout, correct data captured, single DONE cycle.
- No gnt for TIMEOUT_CYCLES -> bus_err pulse, rdata=0, return to IDLE. Separately, rst_n low during WAIT -> dmem_req=0 immediately, all outputs 0.
